// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: data widths, reset PC, fetch FSM states
// and the fetch buffer entry layout.
package cpu_pkg;

    localparam int unsigned ILEN = 32;
    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] INSTR_NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear, push/pop, occupancy count and flags.
// The head entry is visible on head_c without a pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         res_i,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head_c,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty_c,
    output logic                         full_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty_c   = (count == '0);
    assign full_c    = (count == CW'(DEPTH));
    assign do_push_c = push && !full_c;
    assign do_pop_c  = pop && !empty_c;
    assign head_c    = mem[rd_ptr];

    // Clear drops the contents by resetting pointers; storage keeps stale data.
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '{default: '0};
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push_c) - CW'(do_pop_c);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch front end: in-order memory reads tagged with their
// PC, buffered for decode, with redirect and discard of stale responses.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            res_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [ILEN-1:0] mem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_next;

    logic            accepted_c;
    logic            tag_push_c;
    logic            tag_pop_c;
    logic            out_push_c;
    logic            out_pop_c;
    logic [SW-1:0]   credit_used_c;

    logic [XLEN-1:0] tag_head_c;
    logic [CW-1:0]   tag_count;
    logic            tag_empty_c;
    logic            tag_full_c;

    fetch_entry_t    out_wdata_c;
    fetch_entry_t    out_head_c;
    logic [CW-1:0]   out_count;
    logic            out_empty_c;
    logic            out_full_c;
    logic            unused_pc_bits_c;

    assign unused_pc_bits_c = ^redirect_pc_i[1:0];

    // A word leaving the buffer this cycle frees its slot for a new request.
    assign out_pop_c     = instr_valid_o && instr_ready_i;
    assign credit_used_c = SW'(inflight) + SW'(out_count) - SW'(out_pop_c);
    assign mem_req_o     = (state == FETCH) && !redirect_i && (credit_used_c < SW'(DEPTH));
    assign mem_addr_o    = pc;
    assign accepted_c    = mem_gnt_i && (mem_req_o || redirect_i);

    assign instr_valid_o = !out_empty_c;
    assign instr_o       = out_head_c.instr;
    assign instr_pc_o    = out_head_c.pc;
    assign out_wdata_c   = '{pc: tag_head_c, instr: mem_rdata_i};

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            inflight <= inflight_next;
            discard  <= discard_next;
        end
    end

    // Next-state, PC and counter update; a redirect overrides every other event.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        discard_next  = discard;
        tag_push_c    = 1'b0;
        tag_pop_c     = 1'b0;
        out_push_c    = 1'b0;
        inflight_next = inflight + CW'(accepted_c) - CW'(mem_rvalid_i);

        if (redirect_i) begin
            pc_next      = {redirect_pc_i[XLEN-1:2], 2'b00};
            discard_next = inflight_next;
            state_next   = (inflight_next != '0) ? DRAIN : FETCH;
        end else begin
            if (accepted_c) begin
                tag_push_c = 1'b1;
                pc_next    = pc + XLEN'(4);
            end
            if (mem_rvalid_i) begin
                if (discard != '0) begin
                    discard_next = discard - CW'(1);
                end else begin
                    tag_pop_c  = 1'b1;
                    out_push_c = 1'b1;
                end
            end
            case (state)
                IDLE:    state_next = FETCH;
                DRAIN:   if (discard_next == '0) state_next = FETCH;
                default: state_next = state;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_queue (
        .clk_i   (clk_i),
        .res_i   (res_i),
        .clear   (redirect_i),
        .push    (tag_push_c),
        .pop     (tag_pop_c),
        .wdata   (pc),
        .head_c  (tag_head_c),
        .count   (tag_count),
        .empty_c (tag_empty_c),
        .full_c  (tag_full_c)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk_i   (clk_i),
        .res_i   (res_i),
        .clear   (redirect_i),
        .push    (out_push_c),
        .pop     (out_pop_c),
        .wdata   (out_wdata_c),
        .head_c  (out_head_c),
        .count   (out_count),
        .empty_c (out_empty_c),
        .full_c  (out_full_c)
    );

    // Every tracked in-flight read either has a tag waiting or is marked for discard.
    a_tag_balance: assert property (@(posedge clk_i) disable iff (!res_i)
        (SW'(tag_count) + SW'(discard)) == SW'(inflight));
    a_tag_no_overflow: assert property (@(posedge clk_i) disable iff (!res_i)
        tag_push_c |-> !tag_full_c);
    a_tag_no_underflow: assert property (@(posedge clk_i) disable iff (!res_i)
        tag_pop_c |-> !tag_empty_c);
    a_out_no_overflow: assert property (@(posedge clk_i) disable iff (!res_i)
        out_push_c |-> !out_full_c);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory, an ideal
// fetch-stream model and a per-cycle compare process.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        redirect, instr_valid, instr_ready;
    logic [31:0] redirect_pc, instr, instr_pc;

    logic        gnt_en = 1'b1;
    int unsigned mem_lat = 1;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .res_i         (rst_n),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_gnt = gnt_en && mem_req;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000 ^ INSTR_NOP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = tgt;
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    // Instruction memory: in-order responses, each no earlier than its due cycle.
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } rd_t;
    rd_t pend[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end else begin
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = word_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
    end

    // Model: decode must see PCs exp_pc, +4, ... each with its memory word;
    // requests go out as exp_req, +4, ...; a redirect restarts both.
    logic [31:0] exp_pc = RPC, exp_req = RPC;
    logic [31:0] prev_pc, prev_instr, prev_addr, first_pc;
    logic        prev_hold = 1'b0, prev_pend = 1'b0, after_redir = 1'b0;
    int          outstanding = 0, n_grants = 0, n_deliv = 0, stale_rv = 0;
    logic [31:0] req_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc      = RPC;
            exp_req     = RPC;
            prev_hold   = 1'b0;
            prev_pend   = 1'b0;
            after_redir = 1'b0;
            outstanding = 0;
            n_grants    = 0;
            n_deliv     = 0;
            req_log.delete();
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_pc", instr_pc, prev_pc);
                chk("hold_instr", instr, prev_instr);
            end
            if (prev_pend && !redirect) begin
                chk("req_hold", 32'(mem_req), 32'd1);
                chk("addr_hold", mem_addr, prev_addr);
            end
            if (instr_valid && instr_ready) begin
                chk("deliv_pc", instr_pc, exp_pc);
                chk("deliv_instr", instr, word_of(exp_pc));
                if (after_redir) begin
                    first_pc    = instr_pc;
                    after_redir = 1'b0;
                end
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end
            if (mem_rvalid) begin
                outstanding--;
                if (req_log.size() == 0) stale_rv++;
            end
            if (mem_req) chk("req_addr", mem_addr, exp_req);
            if (mem_req && mem_gnt) begin
                pend.push_back('{addr: mem_addr, due: cyc + mem_lat});
                req_log.push_back(mem_addr);
                exp_req = exp_req + 32'd4;
                outstanding++;
                n_grants++;
            end
            prev_hold  = instr_valid && !instr_ready && !redirect;
            prev_pend  = mem_req && !mem_gnt;
            prev_pc    = instr_pc;
            prev_instr = instr;
            prev_addr  = mem_addr;
            if (redirect) begin
                exp_pc      = {redirect_pc[31:2], 2'b00};
                exp_req     = {redirect_pc[31:2], 2'b00};
                after_redir = 1'b1;
                first_pc    = 32'hFFFF_FFFF;
                stale_rv    = mem_rvalid ? 1 : 0;
                req_log.delete();
            end
        end
    end

    initial begin
        int          found;
        int          gaps;
        int          g0;
        logic [31:0] a;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, RPC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);

        // Streaming from reset, 1-cycle memory, decode always ready
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sample(); chk("a_c0_req", 32'(mem_req), 32'd0);
        sample(); chk("a_c1_req", 32'(mem_req), 32'd1); chk("a_c1_addr", mem_addr, 32'h0);
        sample(); chk("a_c2_addr", mem_addr, 32'h4); chk("a_c2_valid", 32'(instr_valid), 32'd0);
        sample();
        chk("a_c3_valid", 32'(instr_valid), 32'd1);
        chk("a_c3_pc", instr_pc, 32'h0);
        chk("a_c3_instr", instr, 32'hA5A5_0013);
        chk("a_c3_addr", mem_addr, 32'h8);
        gaps = 0;
        repeat (16) begin
            sample();
            if (!instr_valid) gaps++;
        end
        chk("a_gaps", 32'(gaps), 32'd0);
        chk("a_deliv", 32'(n_deliv), 32'd17);

        // Decode stalled from reset: credit limits requests to DEPTH
        @(posedge clk);
        #1 rst_n = 1'b0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) sample();
        chk("b_grants", 32'(n_grants), 32'd2);
        chk("b_req", 32'(mem_req), 32'd0);
        chk("b_valid", 32'(instr_valid), 32'd1);
        chk("b_pc", instr_pc, 32'h0);
        chk("b_instr", instr, 32'hA5A5_0013);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        repeat (10) sample();
        chk("b_deliv", 32'(n_deliv), 32'd10);

        // Grant withheld for 3 cycles
        @(posedge clk);
        #1 gnt_en = 1'b0;
        sample();
        a  = mem_addr;
        g0 = n_grants;
        chk("c_req", 32'(mem_req), 32'd1);
        chk("c_addr", a, 32'h30);
        repeat (2) sample();
        chk("c_req_held", 32'(mem_req), 32'd1);
        chk("c_addr_held", mem_addr, a);
        chk("c_no_grant", 32'(n_grants), 32'(g0));
        @(posedge clk);
        #1 gnt_en = 1'b1;
        repeat (4) sample();
        chk("c_regrant", 32'(n_grants - g0), 32'd4);

        // Redirect with two reads in flight
        mem_lat = 3;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            sample();
            if (outstanding == 2) found = 1;
        end
        chk("d_two_inflight", 32'(found), 32'd1);
        pulse_redirect(32'h0000_0103);
        for (int i = 0; i < 40 && after_redir; i++) sample();
        chk("d_first_pc", first_pc, 32'h100);
        chk("d_stale", 32'(stale_rv), 32'd2);
        chk("d_req_seen", 32'(req_log.size() != 0), 32'd1);
        if (req_log.size() != 0) chk("d_first_req", req_log[0], 32'h100);

        // Redirect coinciding with a response and a decode handshake
        mem_lat = 1;
        repeat (12) sample();
        @(posedge clk);
        #1 redirect = 1'b1; redirect_pc = 32'h0000_0200;
        sample();
        chk("e_valid", 32'(instr_valid), 32'd1);
        chk("e_rvalid", 32'(mem_rvalid), 32'd1);
        @(posedge clk);
        #1 redirect = 1'b0;
        sample();
        chk("e_cleared", 32'(instr_valid), 32'd0);
        chk("e_req", 32'(mem_req), 32'd1);
        chk("e_addr", mem_addr, 32'h200);
        for (int i = 0; i < 20 && after_redir; i++) sample();
        chk("e_first_pc", first_pc, 32'h200);
        chk("e_stale", 32'(stale_rv), 32'd1);

        // Wrap past the top of the address space, then reset mid-stream
        pulse_redirect(32'hFFFF_FFFC);
        repeat (8) sample();
        chk("f_req_count", 32'(req_log.size() >= 2), 32'd1);
        if (req_log.size() >= 2) begin
            chk("f_req0", req_log[0], 32'hFFFF_FFFC);
            chk("f_req1", req_log[1], 32'h0000_0000);
        end
        chk("f_wrap_deliv", 32'(after_redir), 32'd0);
        @(posedge clk);
        #2;
        chk("f_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("f_rst_req", 32'(mem_req), 32'd0);
        chk("f_rst_addr", mem_addr, RPC);
        chk("f_rst_valid", 32'(instr_valid), 32'd0);
        chk("f_rst_instr", instr, 32'h0);
        chk("f_rst_pc", instr_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RV32I core. It issues in-order reads to instruction memory and tags each returned word with its PC. It buffers fetched words and hands them to `decode` over a valid/ready handshake. A redirect input lets the execute stage restart fetch at a branch or jump target, with in-flight responses discarded.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: instruction buffer entries, also the maximum number of outstanding memory reads (power of two, ≥2).

Ports:
- `clk_i`, in, 1: single clock, all logic on rising edge.
- `res_i`, in, 1: reset, asynchronous, active-low.
- `mem_req_o`, out, 1: read request to instruction memory.
- `mem_addr_o`, out, 32: request address, bits [1:0] always 0.
- `mem_gnt_i`, in, 1: request accepted this cycle.
- `mem_rvalid_i`, in, 1: read data valid. Exactly one per granted request, in order, ≥1 cycle after grant.
- `mem_rdata_i`, in, 32: read data.
- `redirect_i`, in, 1: restart fetch, one-cycle pulse.
- `redirect_pc_i`, in, 32: new PC. Bits [1:0] are ignored and forced to 0.
- `instr_valid_o`, out, 1: `instr_o`/`instr_pc_o` valid.
- `instr_ready_i`, in, 1: decode accepts the current instruction.
- `instr_o`, out, 32: instruction word to decode.
- `instr_pc_o`, out, 32: PC of `instr_o`.

## Operation
- Registers:
  - `pc`: next address to request.
  - `inflight`: granted requests not yet answered, 0..DEPTH.
  - `discard`: responses still to drop, 0..DEPTH.
  - PC tag queue: DEPTH entries holding the PCs of in-flight requests.
  - Output FIFO: DEPTH entries of {pc, instr}.
- FSM states:
  - IDLE: the reset state. Unconditionally moves to FETCH on the first clock edge.
  - FETCH: requests are issued.
  - DRAIN: waiting out discarded responses; no requests are issued.
- Request rule: `mem_req_o` = (state==FETCH) && !redirect_i && (inflight + fifo_count < DEPTH). `mem_addr_o` = `pc`.
  - While a request is pending without grant, address and request hold stable.
  - The only exception is the redirect cycle, which withdraws the request.
- On grant (without redirect): push `pc` to the tag queue, `pc <= pc + 4`, `inflight += 1`. `pc` wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- On `mem_rvalid_i`: `inflight -= 1`.
  - If `discard` > 0: drop the word and `discard -= 1`.
  - Otherwise: pop the tag queue and push {tag, rdata} into the FIFO. The FIFO is never full here because of the credit rule.
- Output: `instr_valid_o` = FIFO non-empty, and the outputs show the head entry. The head pops when `instr_valid_o && instr_ready_i`. While valid is high and ready is low, outputs hold.
- Redirect (takes priority over all other events in that cycle):
  - `pc <= {redirect_pc_i[31:2], 2'b00}`.
  - Clear the FIFO and the tag queue.
  - `discard <= inflight + gnt - rvalid`, where gnt and rvalid are this cycle's values. A response arriving in the redirect cycle is dropped, and a grant in that cycle counts as in-flight.
  - A handshake in the redirect cycle counts as delivered.
  - Next state is DRAIN if the new `discard` > 0, else FETCH.
- DRAIN → FETCH when `discard` reaches 0.
- A redirect while in DRAIN recomputes `discard` the same way.
- Reset (at any time, mid-burst included) returns every register to its reset value immediately. Responses from before reset are not tracked; the memory is reset together with this block.

## Timing
- Reset values: `mem_req_o`=0, `mem_addr_o`=RESET_PC, `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, state IDLE, all counters 0.
- First `mem_req_o`=1 is in the second cycle after `res_i` rises (IDLE→FETCH edge, then FETCH).
- Response to output: `mem_rvalid_i` sampled at edge N gives `instr_valid_o` from N+1 (registered FIFO).
- Redirect to new request: next cycle if `discard`=0, otherwise the cycle after the last discarded response.
- Throughput: one instruction per cycle sustained, given single-cycle grant and 1-cycle memory latency with DEPTH ≥ 2.

## Structure
- Shared package `cpu_pkg`:
  - `ILEN`=32, `XLEN`=32, `RESET_PC_DEFAULT`.
  - Fetch FSM state enum `fetch_state_t` {IDLE, FETCH, DRAIN}.
  - `INSTR_NOP`=32'h0000_0013, for the bench.
- Sub-module `fetch_fifo`: synchronous FIFO of width 64 and depth DEPTH, with push/pop/clear, count, and empty/full flags. It is used for both the output buffer and (width 32) the tag queue.

## Test plan
- Reset release, memory always grants with 1-cycle latency, `instr_ready_i`=1:
  - addresses 0, 4, 8, … appear back-to-back.
  - `instr_valid_o` continuous from the 4th cycle after release.
  - `instr_pc_o` tracks the address of each word.
- Hold `instr_ready_i`=0 for 10 cycles: exactly DEPTH=2 requests are granted, then `mem_req_o`=0. Outputs hold PC 0. Releasing ready resumes with no loss or duplication.
- `mem_gnt_i` low for 3 cycles with a pending request: `mem_addr_o` stays stable, and exactly one fetch occurs per grant.
- Redirect to 32'h0000_0103 with 2 reads in flight: the next request address is 32'h0000_0100. The 2 stale responses are dropped. The first delivered instruction has PC 32'h100.
- Redirect in the same cycle as `mem_rvalid_i` and a decode handshake: the arriving word is dropped and the handshaken word counts as delivered. No stale instruction appears afterwards.
- Redirect to 32'hFFFF_FFFC: requests go to FFFF_FFFC and then 0000_0000 (wrap). Asserting `res_i`=0 mid-stream forces all outputs to reset values within the same cycle (asynchronous).
